// File: rtl/addsub_sequencer_pkg.sv
// Shared encodings for the add/sub sequencer: expression selects, FSM states
// and the last-step index of each expression.
package addsub_sequencer_pkg;

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_BSUBA  = 2'b01,
    OP_BSUB2A = 2'b10,
    OP_BSUB3A = 2'b11
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  localparam logic [1:0] LAST_STEP_ADD    = 2'd0;
  localparam logic [1:0] LAST_STEP_BSUBA  = 2'd0;
  localparam logic [1:0] LAST_STEP_BSUB2A = 2'd1;
  localparam logic [1:0] LAST_STEP_BSUB3A = 2'd2;

  function automatic logic [1:0] last_step(input op_e op);
    case (op)
      OP_ADD:    last_step = LAST_STEP_ADD;
      OP_BSUBA:  last_step = LAST_STEP_BSUBA;
      OP_BSUB2A: last_step = LAST_STEP_BSUB2A;
      default:   last_step = LAST_STEP_BSUB3A;
    endcase
  endfunction

endpackage

// File: rtl/add_subt_16bits.sv
// 16-bit adder/subtractor: x=0 gives op0+op1, x=1 gives op0+~op1+1.
// On subtraction cout=1 means no borrow.
module add_subt_16bits (
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic        x,
  output logic [15:0] o,
  output logic        cout
);

  logic [15:0] op1_eff;

  assign op1_eff   = x ? ~op1 : op1;
  assign {cout, o} = {1'b0, op0} + {1'b0, op1_eff} + {16'd0, x};

endmodule

// File: rtl/addsub_sequencer.sv
// Evaluates a+b, b-a, b-2a or b-3a over 1..3 cycles on one shared adder,
// under a start/busy/done handshake.
module addsub_sequencer
  import addsub_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] o,
  output logic         cout
);

  // Handshake: start is sampled only while busy=0; busy stays high from the
  // accepting edge until the final step's edge, where done pulses for one cycle.
  state_e      state_q;
  op_e         rop_q;
  logic [W-1:0] ra_q, rb_q, t_q, o_q;
  logic [1:0]  step_q;
  logic        cacc_q, cout_q, busy_q, done_q;

  logic [W-1:0] add_op0, add_op1, add_o;
  logic         add_x, add_cout;

  // Operand steering for the shared adder; step0 of the 2a/3a forms doubles a into t.
  always_comb begin
    add_op0 = rb_q;
    add_op1 = ra_q;
    add_x   = 1'b0;
    case (rop_q)
      OP_ADD:   ;
      OP_BSUBA: add_x = 1'b1;
      OP_BSUB2A: begin
        if (step_q == 2'd0) begin
          add_op0 = ra_q;
        end else begin
          add_op1 = t_q;
          add_x   = 1'b1;
        end
      end
      default: begin
        if (step_q == 2'd0) begin
          add_op0 = ra_q;
        end else if (step_q == 2'd1) begin
          add_op0 = t_q;
        end else begin
          add_op1 = t_q;
          add_x   = 1'b1;
        end
      end
    endcase
  end

  add_subt_16bits u_adder (
    .op0  (add_op0),
    .op1  (add_op1),
    .x    (add_x),
    .o    (add_o),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rop_q   <= OP_ADD;
      ra_q    <= '0;
      rb_q    <= '0;
      t_q     <= '0;
      o_q     <= '0;
      step_q  <= '0;
      cacc_q  <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ra_q    <= a;
            rb_q    <= b;
            rop_q   <= op_e'(op);
            t_q     <= '0;
            step_q  <= '0;
            cacc_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          cacc_q <= cacc_q | add_cout;
          if (step_q == last_step(rop_q)) begin
            o_q     <= add_o;
            cout_q  <= cacc_q | add_cout;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            t_q    <= add_o;
            step_q <= step_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed-vector bench for addsub_sequencer with hand-computed results.
module tb_addsub_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done, cout;
  logic [15:0] o;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  addsub_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .o     (o),
    .cout  (cout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op starting in the current cycle; returns in the done cycle.
  // disturb=1 pulses start with a different op/operands during the first CALC cycle.
  task automatic run_op(input string tag, input logic [1:0] op_v, input logic [15:0] a_v,
                        input logic [15:0] b_v, input logic [15:0] exp_o, input logic exp_c,
                        input int exp_lat, input bit disturb);
    int cycles;
    int busy_cnt;
    logic [16:0] exp_v;
    exp_q.push_back({exp_c, exp_o});
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    tick();
    start    = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    if (disturb) begin
      start = 1'b1;
      op    = 2'b00;
      a     = 16'hAAAA;
      b     = 16'h5555;
    end
    while (!done && cycles < 10) begin
      if (busy) busy_cnt++;
      tick();
      cycles++;
      start = 1'b0;
    end
    exp_v = exp_q.pop_front();
    check({tag, "_timeout"}, {31'd0, done}, 32'd1);
    check({tag, "_lat"}, cycles, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_o"}, {16'd0, o}, {16'd0, exp_v[15:0]});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_v[16]});
  endtask

  initial begin
    int dn;
    rst   = 1'b1;
    start = 1'b1;
    op    = 2'b00;
    a     = 16'h0001;
    b     = 16'h0001;
    tick();
    tick();
    start = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_o", {16'd0, o}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    run_op("b2a_3_10", 2'b10, 16'd3, 16'd10, 16'h0004, 1'b1, 2, 1'b0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);

    run_op("b3a_5_20", 2'b11, 16'd5, 16'd20, 16'h0005, 1'b1, 3, 1'b0);
    tick();

    // back-to-back: second op starts in the first op's done cycle
    run_op("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1, 1'b0);
    run_op("bsuba_b2b", 2'b01, 16'h0010, 16'h0005, 16'hFFF5, 1'b0, 1, 1'b0);
    tick();

    run_op("b2a_8000", 2'b10, 16'h8000, 16'h0007, 16'h0007, 1'b1, 2, 1'b0);
    tick();

    // carry from step1 (3a wraps) must survive a borrowing final step
    run_op("b3a_ignore", 2'b11, 16'h6000, 16'h1000, 16'hF000, 1'b1, 3, 1'b1);
    tick();

    // reset in the second CALC cycle abandons the operation
    start = 1'b1;
    op    = 2'b11;
    a     = 16'd5;
    b     = 16'd20;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_o", {16'd0, o}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);

    run_op("add_after_rst", 2'b00, 16'd2, 16'd3, 16'h0005, 1'b0, 1, 1'b0);
    tick();
    check("final_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_sequencer.md
# addsub_sequencer

Multi-cycle controller that time-shares a single `add_subt_16bits` instance to evaluate small linear expressions of two 16-bit operands (a+b, b−a, b−2a, b−3a). It replaces per-expression chains of parallel adders with one adder, an operand/accumulator register set and a step-sequencing FSM. It sits between the lab's top-level operand switches and the result display, under a start/busy/done handshake.

## Interface
- No parameters; width fixed at 16.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  expression select, latched with `start`: 00 a+b, 01 b−a, 10 b−2a, 11 b−3a.
- `a`  in  16  operand A, latched with `start`.
- `b`  in  16  operand B, latched with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  single-cycle pulse: `o`/`cout` just updated.
- `o`  out  16  result register; holds until the next completion.
- `cout`  out  1  OR of the adder carry-outs from every step of the last operation.

## Operation
- States: IDLE, CALC. The step counter `step` (2 bits) and the latched `op` set the step count N: op00/01 → N=1, op10 → N=2, op11 → N=3.
- IDLE, `start`=1: latch a→ra, b→rb, op→rop. Clear accumulator `t`, `step`=0 and the carry accumulator. Enter CALC.
- CALC, per cycle, the shared adder (op0, op1, x) is driven as follows:
  - op00: (rb, ra, 0).
  - op01: (rb, ra, 1).
  - op10: step0 (ra, ra, 0) → t; step1 (rb, t, 1) → o.
  - op11: step0 (ra, ra, 0) → t; step1 (t, ra, 0) → t; step2 (rb, t, 1) → o.
- On every step, the carry accumulator ORs in the adder's `cout`.
- On the final step: register the result into `o` and cout_acc|adder_cout into `cout`, pulse `done`, and return to IDLE.
- Adder semantics are unchanged: x=1 computes op0 + ~op1 + 1, so on a subtract step `cout`=1 means no borrow. All arithmetic wraps modulo 2^16 and there is no overflow flag.
- `start` while `busy`=1 is ignored; there is no queuing. Changes on `a`/`b`/`op` during CALC have no effect.
- `rst` in any state, including mid-CALC: state←IDLE and busy, done, o, cout, t, ra, rb, rop, step, and the carry accumulator all ←0. The operation is abandoned and `done` is not pulsed.

## Timing
- Reset values: `busy`=0, `done`=0, `o`=0x0000, `cout`=0.
- `start` is accepted at edge E0. `busy`=1 from after E0 through the cycle ending at edge EN. Step k is evaluated in the cycle before edge E(k+1).
- After EN, `o`/`cout` are valid, `done`=1 for exactly one cycle and `busy`=0. Latency from the accepting edge to `done` high is 1/1/2/3 cycles for op 00/01/10/11.
- Back-to-back: `start` asserted during the `done` cycle is accepted (state is IDLE), so a new op can start with no idle gap.
- `done` and `busy` are never high in the same cycle.
- `rst` and `start` high together: reset wins.
- The adder path is combinational within one cycle; there is no multicycle constraint.

## Structure
- A shared package holds the op encodings (OP_ADD, OP_BSUBA, OP_BSUB2A, OP_BSUB3A), the state encoding (IDLE, CALC) and a per-op constant for the last step index (0, 0, 1, 2).
- There is exactly one sub-module instance: the existing `add_subt_16bits`. All other logic (operand muxes, FSM, registers) is local to this block.

## Test plan
- Reset, then op=10, a=3, b=10, one-cycle `start` → `done` 2 cycles after the accept edge, `o`=0x0004, `cout`=1. `busy` is high for exactly 2 cycles.
- op=11, a=5, b=20 → `done` 3 cycles after accept, `o`=0x0005, `cout`=1. The internal t sequence is 10, 15.
- op=00, a=0xFFFF, b=0x0001 → `done` 1 cycle after accept, `o`=0x0000, `cout`=1. Follow with op=01, a=0x0010, b=0x0005 started in the `done` cycle → `o`=0xFFF5, `cout`=0.
- op=10, a=0x8000, b=0x0007 → `o`=0x0007, `cout`=1: step0 carry is 1 and step1 has no borrow.
- op=11 started, then `start` pulsed with op=00 during CALC and `a`/`b` changed → ignored; the original b−3a result is delivered.
- op=11 started, `rst` asserted in the second CALC cycle → next cycle `busy`=0, `done`=0, `o`=0, `cout`=0. No `done` pulse follows. A new op=00 (a=2, b=3) then yields `o`=0x0005.
